// File: rtl/neural_net_pkg.sv
// Shared constants, stage types and saturation helper for the PLL gain-adaptation network.
package neural_net_pkg;

  localparam int W = 8;

  localparam int unsigned DEF_N_TH  = 84;
  localparam int unsigned DEF_KP_HI = 31;
  localparam int unsigned DEF_KP_LO = 10;

  // Hidden-layer outputs plus the forwarded Kp that the output layer offsets.
  typedef struct packed {
    logic         h1;
    logic         h2;
    logic         h3;
    logic [W-1:0] kp;
  } hidden_t;

  typedef struct packed {
    logic [W-1:0] k3;
    logic [W-1:0] k4;
  } coef_t;

  localparam logic signed [W+1:0] SAT_ZERO = '0;
  localparam logic signed [W+1:0] SAT_MAX  = {2'b00, {W{1'b1}}};

  function automatic logic [W-1:0] sat_unsigned(input logic signed [W+1:0] v);
    if (v < SAT_ZERO) return '0;
    if (v > SAT_MAX) return '1;
    return v[W-1:0];
  endfunction

endpackage

// File: rtl/neural_net_hidden_layer.sv
// Hidden layer: three inclusive unsigned comparator neurons registered with the forwarded Kp.
module neural_net_hidden_layer
  import neural_net_pkg::*;
#(
  parameter int unsigned N_TH  = DEF_N_TH,
  parameter int unsigned KP_HI = DEF_KP_HI,
  parameter int unsigned KP_LO = DEF_KP_LO
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] avg_n,
  input  logic [W-1:0] avg_kp,
  output hidden_t      hid,
  output logic         hid_valid
);

  localparam logic [W-1:0] N_TH_C  = W'(N_TH);
  localparam logic [W-1:0] KP_HI_C = W'(KP_HI);
  localparam logic [W-1:0] KP_LO_C = W'(KP_LO);

  hidden_t hid_next;

  always_comb begin
    hid_next    = hid;
    hid_next.h1 = (avg_n  <= N_TH_C);
    hid_next.h2 = (avg_kp <= KP_HI_C);
    hid_next.h3 = (avg_kp >= KP_LO_C);
    hid_next.kp = avg_kp;
  end

  // Data holds while idle; only the valid bit tracks in_valid every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hid       <= '0;
      hid_valid <= 1'b0;
    end else begin
      hid_valid <= in_valid;
      if (in_valid) begin
        hid <= hid_next;
      end
    end
  end

endmodule

// File: rtl/neural_net.sv
// Two-stage threshold network mapping averaged PLL metrics to loop-filter coefficients k3/k4.
// Fixed 2-cycle latency, one result per cycle, outputs hold their last valid values when idle.
module neural_net
  import neural_net_pkg::*;
#(
  parameter int unsigned N_TH  = DEF_N_TH,
  parameter int unsigned KP_HI = DEF_KP_HI,
  parameter int unsigned KP_LO = DEF_KP_LO
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] avg_n,
  input  logic [W-1:0] avg_kp,
  output logic         out_valid,
  output logic [W-1:0] k3,
  output logic [W-1:0] k4
);

  localparam logic signed [W+1:0] ONE = (W+2)'(1);
  localparam logic signed [W+1:0] TWO = (W+2)'(2);

  hidden_t hid;
  logic    hid_valid;

  neural_net_hidden_layer #(
    .N_TH  (N_TH),
    .KP_HI (KP_HI),
    .KP_LO (KP_LO)
  ) u_hidden (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .avg_n     (avg_n),
    .avg_kp    (avg_kp),
    .hid       (hid),
    .hid_valid (hid_valid)
  );

  logic                bump;
  logic                dip;
  logic signed [W+1:0] kp_ext;
  logic signed [W+1:0] bump_ext;
  logic signed [W+1:0] dip_ext;
  logic signed [W+1:0] k3_raw;
  logic signed [W+1:0] k4_raw;
  coef_t               coef_next;
  coef_t               coef;

  // Two guard bits let small Kp go negative before the clamp to zero.
  always_comb begin
    bump            = hid.h1 & hid.h2;
    dip             = hid.h3 & ~bump;
    kp_ext          = signed'({2'b00, hid.kp});
    bump_ext        = signed'({{(W+1){1'b0}}, bump});
    dip_ext         = signed'({{(W+1){1'b0}}, dip});
    k4_raw          = kp_ext - ONE + bump_ext;
    k3_raw          = kp_ext - TWO - dip_ext;
    coef_next       = coef;
    coef_next.k3    = sat_unsigned(k3_raw);
    coef_next.k4    = sat_unsigned(k4_raw);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= hid_valid;
      if (hid_valid) begin
        coef <= coef_next;
      end
    end
  end

  assign k3 = coef.k3;
  assign k4 = coef.k4;

endmodule

// File: tb/tb_neural_net.sv
// Directed bench for neural_net with a per-cycle expectation queue and immediate assertions.
module tb_neural_net;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] avg_n;
  logic [7:0] avg_kp;
  logic       out_valid;
  logic [7:0] k3;
  logic [7:0] k4;

  int checks;
  int failures;

  typedef struct {
    bit         v;
    logic [7:0] k3;
    logic [7:0] k4;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_k3;
  logic [7:0] last_k4;

  neural_net dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .avg_n     (avg_n),
    .avg_kp    (avg_kp),
    .out_valid (out_valid),
    .k3        (k3),
    .k4        (k4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Stage 1 is empty after reset, so one invalid entry stands in for it.
  task automatic reset_model();
    exp_t e;
    exp_q.delete();
    e.v = 1'b0; e.k3 = 8'd0; e.k4 = 8'd0;
    exp_q.push_back(e);
    last_k3 = 8'd0;
    last_k4 = 8'd0;
  endtask

  // Drive one input, clock it, then compare the result emerging from two cycles earlier.
  task automatic cycle(input string tag, input bit v, input logic [7:0] n, input logic [7:0] kp,
                       input logic [7:0] ek3, input logic [7:0] ek4);
    exp_t e;
    exp_t o;
    in_valid = v;
    avg_n    = n;
    avg_kp   = kp;
    e.v = v; e.k3 = ek3; e.k4 = ek4;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    o = exp_q.pop_front();
    if (o.v) begin
      last_k3 = o.k3;
      last_k4 = o.k4;
    end
    check({tag, ".vld"}, {7'd0, out_valid}, {7'd0, o.v});
    check({tag, ".k3"}, k3, last_k3);
    check({tag, ".k4"}, k4, last_k4);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    avg_n    = 8'($urandom_range(0, 255));
    avg_kp   = 8'($urandom_range(0, 255));
    reset_model();

    // Reset with random valid inputs.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      in_valid = 1'($urandom_range(0, 1));
      avg_n    = 8'($urandom_range(0, 255));
      avg_kp   = 8'($urandom_range(0, 255));
      @(negedge clk);
      check("rst.vld", {7'd0, out_valid}, 8'd0);
      check("rst.k3", k3, 8'd0);
      check("rst.k4", k4, 8'd0);
    end
    rst_n = 1'b1;
    reset_model();

    cycle("first", 1'b1, 8'd87, 8'd4, 8'd2, 8'd3);
    cycle("s0", 1'b1, 8'd87, 8'd9,  8'd7,  8'd8);
    cycle("s1", 1'b1, 8'd88, 8'd12, 8'd9,  8'd11);
    cycle("s2", 1'b1, 8'd84, 8'd31, 8'd29, 8'd31);
    cycle("s3", 1'b1, 8'd83, 8'd20, 8'd18, 8'd20);
    cycle("s4", 1'b1, 8'd95, 8'd5,  8'd3,  8'd4);
    cycle("s5", 1'b1, 8'd81, 8'd33, 8'd30, 8'd32);

    cycle("e_n84", 1'b1, 8'd84, 8'd31, 8'd29, 8'd31);
    cycle("e_n85", 1'b1, 8'd85, 8'd31, 8'd28, 8'd30);
    cycle("e_kp32", 1'b1, 8'd80, 8'd32, 8'd29, 8'd31);
    cycle("e_kp10", 1'b1, 8'd90, 8'd10, 8'd7,  8'd9);
    cycle("e_kp9", 1'b1, 8'd90, 8'd9,  8'd7,  8'd8);

    cycle("sat0", 1'b1, 8'd90, 8'd0,   8'd0,   8'd0);
    cycle("sat1", 1'b1, 8'd90, 8'd1,   8'd0,   8'd0);
    cycle("sat2", 1'b1, 8'd80, 8'd1,   8'd0,   8'd1);
    cycle("sat3", 1'b1, 8'd90, 8'd255, 8'd252, 8'd254);

    // Valid gap: held outputs are checked through last_k3/last_k4.
    cycle("gap_a", 1'b1, 8'd87, 8'd9,  8'd7, 8'd8);
    cycle("gap_b", 1'b0, 8'd20, 8'd200, 8'd0, 8'd0);
    cycle("gap_c", 1'b1, 8'd88, 8'd12, 8'd9, 8'd11);
    cycle("gap_d", 1'b0, 8'd0,  8'd0,  8'd0, 8'd0);
    cycle("gap_e", 1'b0, 8'd0,  8'd0,  8'd0, 8'd0);
    cycle("gap_f", 1'b0, 8'd0,  8'd0,  8'd0, 8'd0);

    // Mid-stream asynchronous reset with two results in flight.
    cycle("mr_a", 1'b1, 8'd83, 8'd20, 8'd18, 8'd20);
    cycle("mr_b", 1'b1, 8'd90, 8'd255, 8'd252, 8'd254);
    in_valid = 1'b1;
    avg_n    = 8'd95;
    avg_kp   = 8'd5;
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_async.vld", {7'd0, out_valid}, 8'd0);
    check("mr_async.k3", k3, 8'd0);
    check("mr_async.k4", k4, 8'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    cycle("mr_c", 1'b0, 8'd0,  8'd0,  8'd0, 8'd0);
    cycle("mr_d", 1'b0, 8'd0,  8'd0,  8'd0, 8'd0);
    cycle("mr_e", 1'b1, 8'd88, 8'd12, 8'd9, 8'd11);
    cycle("mr_f", 1'b0, 8'd0,  8'd0,  8'd0, 8'd0);
    cycle("mr_g", 1'b0, 8'd0,  8'd0,  8'd0, 8'd0);
    cycle("mr_h", 1'b0, 8'd0,  8'd0,  8'd0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neural_net.md
Name: neural_net

Overview:
- Gain-adaptation block for the PLL loop filter.
- Maps averaged PLL measurements (avg_n: averaged divider/phase metric; avg_kp: averaged proportional gain) to two loop-filter coefficients, k3 and k4.
- Realised as a fixed two-layer threshold-logic network: a hidden layer of comparator "neurons" followed by an output layer of offset adders.
- Two-stage registered pipeline between the averaging unit and the loop-filter coefficient registers.

Parameters:
- N_TH, 84: hidden neuron h1 fires when avg_n <= N_TH.
- KP_HI, 31: hidden neuron h2 fires when avg_kp <= KP_HI.
- KP_LO, 10: hidden neuron h3 fires when avg_kp >= KP_LO.
- W, 8: width of all data inputs and outputs.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: avg_n and avg_kp are valid this cycle.
- avg_n, input, W: averaged N metric, unsigned.
- avg_kp, input, W: averaged Kp, unsigned.
- out_valid, output, 1: k3 and k4 are valid this cycle.
- k3, output, W: coefficient k3, unsigned.
- k4, output, W: coefficient k4, unsigned.

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline registers clear; k3=0, k4=0, out_valid=0. Outputs hold these values until the first valid result emerges.
- Stage 1 (hidden layer), registered on a clk edge when in_valid=1:
  - h1 = (avg_n <= N_TH)
  - h2 = (avg_kp <= KP_HI)
  - h3 = (avg_kp >= KP_LO)
  - avg_kp is forwarded into the stage register.
  - All comparisons are unsigned and inclusive.
- Stage 2 (output layer):
  - bump = h1 AND h2
  - dip = h3 AND NOT bump
  - k4 = avg_kp - 1 + bump
  - k3 = avg_kp - 2 - dip
- Arithmetic: computed at W+2 bits signed, then saturated to [0, 2^W-1].
  - Example: avg_kp=0 gives k3=0 and k4=0.
  - k4 never exceeds 254, because bump requires avg_kp <= 31.
- Latency: exactly 2 cycles. out_valid is in_valid delayed by 2 cycles.
- Throughput: one result per cycle, no backpressure.
- When in_valid=0:
  - Stage registers hold their previous data.
  - out_valid deasserts 2 cycles later.
  - k3/k4 keep their last valid values.
- Reset asserted mid-operation: in-flight results are discarded. out_valid=0 in the first cycle after reset release, and stays 0 until a new in_valid has propagated 2 cycles.
- No X propagation: every register has a reset value.

Decomposition:
- Shared package neural_net_pkg holds:
  - default thresholds (N_TH, KP_HI, KP_LO)
  - W
  - a saturate-to-unsigned function
- One sub-module, neural_net_hidden_layer: the three comparators plus the stage-1 register.
- The output layer, saturation and valid pipeline stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> k3=0, k4=0, out_valid=0. Release, then apply avg_n=87, avg_kp=4, in_valid=1 -> two cycles later out_valid=1, k3=2, k4=3.
- Streaming vectors, back to back, one per cycle; each result appears 2 cycles after its input:
  - (87,9) -> k3=7, k4=8
  - (88,12) -> k3=9, k4=11
  - (84,31) -> k3=29, k4=31
  - (83,20) -> k3=18, k4=20
  - (95,5) -> k3=3, k4=4
  - (81,33) -> k3=30, k4=32
- Threshold edges:
  - (84,31) vs (85,31) -> k4=31 vs 30, k3=29 vs 28
  - (80,32) -> k3=29, k4=31
  - (90,10) vs (90,9) -> k3=7 vs 7, k4=9 vs 8
- Saturation:
  - (90,0) -> k3=0, k4=0
  - (90,1) -> k3=0, k4=0
  - (80,1) -> k3=0, k4=1
  - (90,255) -> k3=252, k4=254
- Valid gaps: in_valid toggles 1,0,1 -> out_valid follows 2 cycles later; k3/k4 hold their last values during the gap.
- Mid-stream reset: assert rst_n=0 asynchronously between clk edges while results are in flight -> outputs go to 0 immediately; nothing is produced for the flushed inputs.
